// File: rtl/rescale_relu_array.sv
// Multi-lane requantiser: per-lane multiply by m0, rounding arithmetic shift by n,
// ReLU and saturation to OUT_W, with cnt/pos/valid travelling at the same 2-stage latency.
module rescale_relu_array #(
  parameter int CH      = 4,
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int M_W     = 8,
  parameter int SH_W    = 5,
  parameter int CNT_W   = 5,
  parameter int POS_W   = 4,
  parameter int M0_INIT = 59,
  parameter int N_INIT  = 11,
  parameter int ROUND   = 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [CH*IN_W-1:0]    in_data,
  input  logic [CNT_W-1:0]      cnt_in,
  input  logic [POS_W-1:0]      pos_in,
  input  logic                  cfg_we,
  input  logic [M_W-1:0]        cfg_m0,
  input  logic [SH_W-1:0]       cfg_n,
  output logic                  out_valid,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic [CNT_W-1:0]      cnt_out,
  output logic [POS_W-1:0]      pos_out,
  output logic                  busy,
  output logic                  cfg_err,
  output logic [15:0]           sat_cnt
);

  localparam int PW = IN_W + M_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] OMAX_S = SW'(2**(OUT_W-1) - 1);

  logic signed [M_W-1:0]  m0_act;
  logic        [SH_W-1:0] n_act;

  logic signed [PW-1:0]   s1_p [CH];
  logic                   s1_valid;
  logic [CNT_W-1:0]       s1_cnt;
  logic [POS_W-1:0]       s1_pos;

  logic signed [PW-1:0]   prod [CH];
  logic [CH*OUT_W-1:0]    res_pack;
  logic [CH-1:0]          lane_sat;
  logic [15:0]            n_sat;
  logic [16:0]            sat_sum;
  logic [SW-1:0]          rnd_term;
  logic                   cfg_ok;

  assign busy   = s1_valid | out_valid;
  assign cfg_ok = cfg_we & ~busy & ~in_valid;

  // Both multiplicands are signed, so they are sign-extended to PW before multiplying.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      prod[k] = $signed(in_data[k*IN_W +: IN_W]) * m0_act;
    end
  end

  always_comb begin
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] r;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    res_pack = '0;
    lane_sat = '0;
    n_sat    = '0;
    s        = '0;
    r        = '0;
    rnd_term = (ROUND != 0 && n_act != '0) ? (SW'(1) << (n_act - SH_W'(1))) : '0;
    for (int k = 0; k < CH; k++) begin
      s = {s1_p[k][PW-1], s1_p[k]} + rnd_term;
      r = s >>> n_act;
      if (r[SW-1]) begin
        res_pack[k*OUT_W +: OUT_W] = '0;
      end else if (r > OMAX_S) begin
        res_pack[k*OUT_W +: OUT_W] = OMAX_S[OUT_W-1:0];
        lane_sat[k]                = 1'b1;
      end else begin
        res_pack[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
      end
      n_sat = n_sat + 16'(lane_sat[k]);
    end
    sat_sum = {1'b0, sat_cnt} + {1'b0, n_sat};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      // NOTE: the lane product flops are reset too; it is a small flop array, not a RAM,
      // and it keeps out_data deterministic after reset.
      for (int k = 0; k < CH; k++) s1_p[k] <= '0;
      s1_valid  <= 1'b0;
      s1_cnt    <= '0;
      s1_pos    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt_out   <= '0;
      pos_out   <= '0;
    end else if (en) begin
      for (int k = 0; k < CH; k++) s1_p[k] <= prod[k];
      s1_valid  <= in_valid;
      s1_cnt    <= cnt_in;
      s1_pos    <= pos_in;
      out_valid <= s1_valid;
      out_data  <= res_pack;
      cnt_out   <= s1_cnt;
      pos_out   <= s1_pos;
    end
  end

  // Config loads ignore en; an accepted load can never coincide with a valid stage-2 capture.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m0_act  <= M_W'(M0_INIT);
      n_act   <= SH_W'(N_INIT);
      cfg_err <= 1'b0;
      sat_cnt <= '0;
    end else begin
      cfg_err <= cfg_we & ~cfg_ok;
      if (cfg_ok) begin
        m0_act  <= cfg_m0;
        n_act   <= cfg_n;
        sat_cnt <= '0;
      end else if (en && s1_valid) begin
        sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_rescale_relu_array.sv
// Directed bench for rescale_relu_array: ROUND=1 and ROUND=0 instances share stimulus and are
// checked every cycle against a beat-indexed arithmetic model, plus hand-computed literals.
module tb_rescale_relu_array;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [4:0]   cnt_in = '0;
  logic [3:0]   pos_in = '0;
  logic         cfg_we = 1'b0;
  logic [7:0]   cfg_m0 = '0;
  logic [4:0]   cfg_n = '0;

  logic        ov_a, ov_b, bz_a, bz_b, ce_a, ce_b;
  logic [31:0] od_a, od_b;
  logic [4:0]  co_a, co_b;
  logic [3:0]  po_a, po_b;
  logic [15:0] sc_a, sc_b;

  always #5 clk = ~clk;

  rescale_relu_array #(.ROUND(1)) dut (
    .clk(clk), .rst_b(rst_b), .en(en), .in_valid(in_valid), .in_data(in_data),
    .cnt_in(cnt_in), .pos_in(pos_in), .cfg_we(cfg_we), .cfg_m0(cfg_m0), .cfg_n(cfg_n),
    .out_valid(ov_a), .out_data(od_a), .cnt_out(co_a), .pos_out(po_a),
    .busy(bz_a), .cfg_err(ce_a), .sat_cnt(sc_a));

  rescale_relu_array #(.ROUND(0)) dut_t (
    .clk(clk), .rst_b(rst_b), .en(en), .in_valid(in_valid), .in_data(in_data),
    .cnt_in(cnt_in), .pos_in(pos_in), .cfg_we(cfg_we), .cfg_m0(cfg_m0), .cfg_n(cfg_n),
    .out_valid(ov_b), .out_data(od_b), .cnt_out(co_b), .pos_out(po_b),
    .busy(bz_b), .cfg_err(ce_b), .sat_cnt(sc_b));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: beat index = number of enabled edges so far. After edge k, stage 1 holds beat k
  // and the outputs show beat k-1.
  localparam int SLOTS = 4096;
  int          k = 1;
  bit          mv   [SLOTS];
  logic [31:0] md_a [SLOTS];
  logic [31:0] md_b [SLOTS];
  logic [4:0]  mc   [SLOTS];
  logic [3:0]  mp   [SLOTS];
  int          ms_a [SLOTS];
  int          ms_b [SLOTS];
  int          m0_m = 59;
  int          n_m  = 11;
  int          es_a = 0;
  int          es_b = 0;
  bit          exp_ce = 1'b0;

  function automatic logic [7:0] rq(input logic [31:0] x, input int m0, input int n,
                                    input bit rnd, output bit sat);
    longint p;
    p = longint'($signed(x)) * longint'(m0);
    if (rnd && n > 0) p = p + (longint'(1) << (n - 1));
    p   = p >>> n;
    sat = 1'b0;
    if (p < 0) return 8'd0;
    if (p > 127) begin
      sat = 1'b1;
      return 8'd127;
    end
    return 8'(p);
  endfunction

  always @(negedge rst_b) begin
    for (int i = 0; i < SLOTS; i++) mv[i] = 1'b0;
    m0_m = 59; n_m = 11; es_a = 0; es_b = 0; exp_ce = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_b) begin
      bit busy_m, acc, s;
      busy_m = mv[k] || mv[k-1];
      acc    = cfg_we && !busy_m && !in_valid;
      exp_ce = cfg_we && !acc;
      if (en) begin
        k++;
        mv[k] = in_valid;
        mc[k] = cnt_in;
        mp[k] = pos_in;
        ms_a[k] = 0;
        ms_b[k] = 0;
        for (int l = 0; l < 4; l++) begin
          md_a[k][l*8 +: 8] = rq(in_data[l*32 +: 32], m0_m, n_m, 1'b1, s);
          ms_a[k] += int'(s);
          md_b[k][l*8 +: 8] = rq(in_data[l*32 +: 32], m0_m, n_m, 1'b0, s);
          ms_b[k] += int'(s);
        end
        if (mv[k-1]) begin
          es_a = (es_a + ms_a[k-1] > 65535) ? 65535 : es_a + ms_a[k-1];
          es_b = (es_b + ms_b[k-1] > 65535) ? 65535 : es_b + ms_b[k-1];
        end
      end
      if (acc) begin
        m0_m = int'($signed(cfg_m0));
        n_m  = int'(cfg_n);
        es_a = 0;
        es_b = 0;
      end
    end
  end

  task automatic cmp_one(input string tag, input logic ov, input logic [31:0] od,
                         input logic [4:0] co, input logic [3:0] po, input logic bz,
                         input logic ce, input logic [15:0] sc,
                         input logic [31:0] ed, input int es);
    check({tag, ".out_valid"}, 64'(ov), 64'(mv[k-1]));
    check({tag, ".busy"}, 64'(bz), 64'(mv[k] || mv[k-1]));
    check({tag, ".cfg_err"}, 64'(ce), 64'(exp_ce));
    check({tag, ".sat_cnt"}, 64'(sc), 64'(es));
    if (mv[k-1]) begin
      check({tag, ".out_data"}, 64'(od), 64'(ed));
      check({tag, ".cnt_out"}, 64'(co), 64'(mc[k-1]));
      check({tag, ".pos_out"}, 64'(po), 64'(mp[k-1]));
    end
  endtask

  always @(negedge clk) begin
    cmp_one("r1", ov_a, od_a, co_a, po_a, bz_a, ce_a, sc_a, md_a[k-1], es_a);
    cmp_one("r0", ov_b, od_b, co_b, po_b, bz_b, ce_b, sc_b, md_b[k-1], es_b);
  end

  task automatic step(input bit e, input bit v, input int l0, input int l1, input int l2,
                      input int l3, input int c, input int p);
    @(negedge clk);
    en = e; in_valid = v; cfg_we = 1'b0;
    in_data = {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    cnt_in = 5'(c); pos_in = 4'(p);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfgld(input int m0, input int n, input bit e, input bit v);
    @(negedge clk);
    en = e; in_valid = v; cfg_we = 1'b1;
    cfg_m0 = 8'(m0); cfg_n = 5'(n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset.out_valid", 64'(ov_a), 64'd0);
    check("reset.out_data", 64'(od_a), 64'd0);
    check("reset.busy", 64'(bz_a), 64'd0);
    check("reset.sat_cnt", 64'(sc_a), 64'd0);
    check("reset.cnt_pos", 64'({co_a, po_a}), 64'd0);
    #2 rst_b = 1'b1;

    // Default config, mixed lanes.
    step(1, 1, 1000, 35, 17, -500, 3, 5);
    idle(); idle();
    check("dflt.out_data", 64'(od_a), 64'h0000_011D);
    check("dflt.trunc_lane0", 64'(od_b[7:0]), 64'd28);
    check("dflt.cnt_pos", 64'({co_a, po_a}), 64'({5'd3, 4'd5}));
    check("dflt.sat_cnt", 64'(sc_a), 64'd0);

    // Saturating lane, three beats back to back.
    for (int i = 1; i <= 3; i++) step(1, 1, 100000, 0, 0, 0, i, i + 8);
    idle(); idle(); idle();
    check("sat.sat_cnt", 64'(sc_a), 64'd3);

    // Load M0=1, N=0 on an empty pipeline.
    cfgld(1, 0, 1, 0);
    idle();
    check("cfg1.sat_cleared", 64'(sc_a), 64'd0);
    step(1, 1, 100, 0, 0, 0, 7, 1);
    idle(); idle();
    check("cfg1.lane0", 64'(od_a[7:0]), 64'd100);
    idle();

    // Negative multiplier.
    cfgld(-59, 11, 1, 0);
    step(1, 1, -1000, 0, 0, 0, 1, 2);
    step(1, 1, 1000, 0, 0, 0, 2, 3);
    idle();
    check("neg.lane0_a", 64'(od_a[7:0]), 64'd29);
    idle();
    check("neg.lane0_b", 64'(od_a[7:0]), 64'd0);
    idle(); idle();

    // Largest shift with extreme inputs.
    cfgld(127, 31, 1, 0);
    step(1, 1, 32'h7FFF_FFFF, 32'h8000_0000, 0, -1, 4, 4);
    idle(); idle(); idle();

    // Rejected load: in_valid high with en low, idle pipeline.
    cfgld(5, 3, 0, 1);
    idle();
    check("rej_iv.cfg_err", 64'(ce_a), 64'd1);
    idle();
    check("rej_iv.cfg_err_clear", 64'(ce_a), 64'd0);

    // Accepted load with en low back to defaults.
    cfgld(59, 11, 0, 0);
    idle();
    check("en0_load.cfg_err", 64'(ce_a), 64'd0);

    // Stall mid-stream; load attempt while busy must be rejected.
    step(1, 1, 2000, 100, -7, 90000, 10, 1);
    step(1, 1, 3000, 200, 50000, 0, 11, 2);
    step(0, 1, 4000, 300, 0, 1, 12, 3);
    step(0, 1, 4000, 300, 0, 1, 12, 3);
    cfgld(9, 9, 0, 0);
    step(0, 1, 4000, 300, 0, 1, 12, 3);
    check("stall.cfg_err", 64'(ce_a), 64'd1);
    step(0, 1, 4000, 300, 0, 1, 12, 3);
    step(1, 1, 4000, 300, 0, 1, 12, 3);
    idle(); idle(); idle();

    // Reset with two beats in flight.
    cfgld(1, 0, 1, 0);
    step(1, 1, 1000, 0, 0, 0, 20, 6);
    step(1, 1, 1000, 0, 0, 0, 21, 7);
    @(negedge clk);
    #2 rst_b = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_mid.out_valid", 64'(ov_a), 64'd0);
    check("rst_mid.out_data", 64'(od_a), 64'd0);
    check("rst_mid.busy", 64'(bz_a), 64'd0);
    check("rst_mid.cnt_pos", 64'({co_a, po_a}), 64'd0);
    @(negedge clk); @(negedge clk);
    #2 rst_b = 1'b1;
    idle(); idle(); idle();
    step(1, 1, 1000, 0, 0, 0, 2, 2);
    idle(); idle();
    check("rst_mid.cfg_restored", 64'(od_a[7:0]), 64'd29);
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
